// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_pkg
//  Description : Opcodes, instruction field positions and fetch FSM states
//                shared by the miniRISC fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam logic [5:0] OP_ALU0 = 6'b000000;
    localparam logic [5:0] OP_ALU1 = 6'b000001;
    localparam logic [5:0] OP_LUI  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_ANDI = 6'b000100;
    localparam logic [5:0] OP_ORI  = 6'b000101;
    localparam logic [5:0] OP_XORI = 6'b000110;
    localparam logic [5:0] OP_LW   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b001000;
    localparam logic [5:0] OP_B    = 6'b001001;
    localparam logic [5:0] OP_BL   = 6'b001010;
    localparam logic [5:0] OP_BR   = 6'b001011;
    localparam logic [5:0] OP_BZ   = 6'b001100;
    localparam logic [5:0] OP_BNZ  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNC_MSB  = 4;
    localparam int FUNC_LSB  = 0;
    localparam int LBL16_MSB = 15;
    localparam int LBL26_MSB = 25;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_FETCH = 2'd0;
    localparam fsm_state_t S_WAIT  = 2'd1;
    localparam fsm_state_t S_ISSUE = 2'd2;
    localparam fsm_state_t S_HALT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection: sequential, register
//                target, or PC-relative 16/26-bit label.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0]    pc,
    input  logic [LBL26_MSB:0] instr_lbl,
    input  logic               is_branch,
    input  logic               branch_taken,
    input  logic               branch_addr_sel,
    input  logic               lbl_sel,
    input  logic [PC_W-1:0]    rs_data,
    output logic [PC_W-1:0]    next_pc
);

    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_off16;
    logic [PC_W-1:0] w_off26;

    assign w_pc_plus1 = pc + PC_W'(1);
    assign w_off16    = {{(PC_W-LBL16_MSB-1){instr_lbl[LBL16_MSB]}}, instr_lbl[LBL16_MSB:0]};
    assign w_off26    = {{(PC_W-LBL26_MSB-1){instr_lbl[LBL26_MSB]}}, instr_lbl};

    always_comb begin
        next_pc = w_pc_plus1;
        if (is_branch && branch_taken) begin
            if (branch_addr_sel) begin
                next_pc = rs_data;
            end else if (lbl_sel) begin
                next_pc = w_pc_plus1 + w_off16;
            end else begin
                next_pc = w_pc_plus1 + w_off26;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : miniRISC fetch front end: PC, synchronous ROM fetch and
//                valid/ready issue to the decoder/execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int               PC_W        = 32,
    parameter int               IMEM_AW     = 10,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    parameter logic [5:0]       HALT_OPCODE = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [5:0]         opcode,
    output logic [4:0]         func,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               is_branch,
    input  logic               branch_addr_sel,
    input  logic               lbl_sel,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    rs_data,
    output logic               halted
);

    fsm_state_t      r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;
    logic            r_halted;
    logic [PC_W-1:0] w_next_pc;
    logic            w_fire;

    // r_valid is only ever set in S_ISSUE, so it alone qualifies the handshake
    assign w_fire = r_valid & instr_ready;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc              (r_pc),
        .instr_lbl       (r_instr[LBL26_MSB:0]),
        .is_branch       (is_branch),
        .branch_taken    (branch_taken),
        .branch_addr_sel (branch_addr_sel),
        .lbl_sel         (lbl_sel),
        .rs_data         (rs_data),
        .next_pc         (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_instr <= imem_rdata;
                    r_valid <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_fire) begin
                        r_valid <= 1'b0;
                        if (r_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: r_halted <= 1'b1;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // The strobe is gated by rst so no ROM read is launched while in reset
    assign imem_en     = (r_state == S_FETCH) && !rst;
    assign imem_addr   = r_pc[IMEM_AW-1:0];
    assign instr       = r_instr;
    assign opcode      = r_instr[OPC_MSB:OPC_LSB];
    assign func        = r_instr[FUNC_MSB:FUNC_LSB];
    assign pc          = r_pc;
    assign pc_plus1    = r_pc + PC_W'(1);
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with a ROM model,
//                directed vectors and a randomized reference-model run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        instr_valid;
    logic        instr_ready;
    logic        is_branch;
    logic        branch_addr_sel;
    logic        lbl_sel;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic        halted;

    logic [31:0] rom [0:1023];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .opcode          (opcode),
        .func            (func),
        .pc              (pc),
        .pc_plus1        (pc_plus1),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .is_branch       (is_branch),
        .branch_addr_sel (branch_addr_sel),
        .lbl_sel         (lbl_sel),
        .branch_taken    (branch_taken),
        .rs_data         (rs_data),
        .halted          (halted)
    );

    typedef struct {
        logic [31:0] start;
        logic [31:0] word;
        logic        br;
        logic        asel;
        logic        lsel;
        logic        tkn;
        logic [31:0] rs;
        logic [31:0] exp_next;
    } vec_t;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        is_branch       = 1'b0;
        branch_addr_sel = 1'b0;
        lbl_sel         = 1'b0;
        branch_taken    = 1'b0;
        rs_data         = '0;
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        instr_ready = 1'b0;
        clear_ctl();
        repeat (n) step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: instr_valid timeout", name);
        end
    endtask

    task automatic fire();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        clear_ctl();
        #1;
    endtask

    // Reach an arbitrary PC by retiring a register branch from RESET_PC
    task automatic goto_pc(input logic [31:0] target);
        bit ok;
        do_reset(2);
        rom[0] = 32'h2C00_0000;
        wait_valid("goto", ok);
        is_branch       = 1'b1;
        branch_addr_sel = 1'b1;
        branch_taken    = 1'b1;
        rs_data         = target;
        fire();
    endtask

    // Reference next-PC from the architectural rules
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit br, input bit asel, input bit lsel,
                                             input bit tkn, input logic [31:0] rs);
        logic signed [15:0] s16;
        logic signed [25:0] s26;
        int                 off;
        if (!(br && tkn)) return cur + 32'd1;
        if (asel) return rs;
        s16 = w[15:0];
        s26 = w[25:0];
        off = lsel ? int'(s16) : int'(s26);
        return cur + 32'd1 + off;
    endfunction

    initial begin
        vec_t        vecs [11];
        vec_t        v;
        bit          ok;
        int          prev_cyc;
        int          pulses;
        int          k;
        logic [31:0] model_pc;
        logic [31:0] w;
        logic [31:0] seqw [3];
        logic [31:0] hold_instr;

        vecs[0]  = '{32'd4,        32'h3000_FFFD, 1, 0, 1, 1, 32'h0,   32'd2};
        vecs[1]  = '{32'd4,        32'h3000_FFFD, 1, 0, 1, 0, 32'h0,   32'd5};
        vecs[2]  = '{32'd4,        32'h2400_000A, 1, 0, 0, 1, 32'h0,   32'd15};
        vecs[3]  = '{32'd4,        32'h2C00_0000, 1, 1, 0, 1, 32'h40,  32'h40};
        vecs[4]  = '{32'd7,        32'h2800_0010, 1, 0, 0, 1, 32'h0,   32'd24};
        vecs[5]  = '{32'd9,        32'h0C00_0123, 0, 1, 1, 1, 32'h55,  32'd10};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h2400_0000, 1, 0, 0, 1, 32'h0,  32'h0};
        vecs[7]  = '{32'd5,        32'h27FF_FFFF, 1, 0, 0, 1, 32'h0,   32'd5};
        vecs[8]  = '{32'd4,        32'h3155_0003, 1, 0, 1, 1, 32'h0,   32'd8};
        vecs[9]  = '{32'hFFFF_FFFE, 32'h3000_000F, 1, 0, 1, 1, 32'h0,  32'hE};
        vecs[10] = '{32'h123,      32'h2C00_0000, 1, 1, 0, 0, 32'h999, 32'h124};

        for (int i = 0; i < 1024; i++) rom[i] = '0;
        seqw[0] = 32'h0022_0801;
        seqw[1] = 32'h0443_1005;
        seqw[2] = 32'h0C00_0123;
        for (int i = 0; i < 3; i++) rom[i] = seqw[i];
        rom[3] = 32'hFC00_0000;

        // Reset state
        rst = 1'b1; instr_ready = 1'b0; clear_ctl();
        repeat (2) step();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_imem_en", {31'd0, imem_en}, 32'd1);
        chk("rel_imem_addr", {22'd0, imem_addr}, 32'd0);

        // Back-to-back issue with ready tied high
        instr_ready = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            wait_valid("seq", ok);
            if (!ok) break;
            w = seqw[i];
            chk("seq_pc", pc, i);
            chk("seq_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
            chk("seq_func", {27'd0, func}, {27'd0, w[4:0]});
            if (i > 0) chk("seq_interval", cyc - prev_cyc, 32'd3);
            prev_cyc = cyc;
            step();
        end
        instr_ready = 1'b0;

        // Stall at pc=1
        do_reset(2);
        instr_ready = 1'b1;
        wait_valid("stall0", ok);
        step();
        instr_ready = 1'b0;
        wait_valid("stall1", ok);
        hold_instr = instr;
        chk("stall_instr0", hold_instr, seqw[1]);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", instr, seqw[1]);
            chk("stall_pc", pc, 32'd1);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
        end
        fire();
        chk("adv_pc", pc, 32'd2);
        chk("adv_valid", {31'd0, instr_valid}, 32'd0);
        chk("adv_imem_en", {31'd0, imem_en}, 32'd1);
        chk("adv_imem_addr", {22'd0, imem_addr}, 32'd2);

        // Reset during the ROM wait of pc=2
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_imem_en", {31'd0, imem_en}, 32'd1);
        chk("midrst_imem_addr", {22'd0, imem_addr}, 32'd0);
        wait_valid("midrst", ok);
        chk("midrst_refetch", instr, seqw[0]);

        // Halt at pc=3
        do_reset(2);
        instr_ready = 1'b1;
        k = 0;
        while (!halted && k < 40) begin
            step();
            k++;
        end
        instr_ready = 1'b0;
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'd3);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            step();
            if (imem_en || instr_valid || !halted) pulses++;
        end
        instr_ready = 1'b0;
        chk("halt_quiet", pulses, 32'd0);

        // Directed branch vectors
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            goto_pc(v.start);
            rom[v.start[9:0]] = v.word;
            chk("vec_fetch_addr", {22'd0, imem_addr}, {22'd0, v.start[9:0]});
            wait_valid("vec", ok);
            if (!ok) continue;
            chk("vec_pc", pc, v.start);
            chk("vec_instr", instr, v.word);
            chk("vec_pc_plus1", pc_plus1, v.start + 32'd1);
            is_branch       = v.br;
            branch_addr_sel = v.asel;
            lbl_sel         = v.lsel;
            branch_taken    = v.tkn;
            rs_data         = v.rs;
            fire();
            chk("vec_next_pc", pc, v.exp_next);
            chk("vec_next_addr", {22'd0, imem_addr}, {22'd0, v.exp_next[9:0]});
            chk("vec_next_en", {31'd0, imem_en}, 32'd1);
        end

        // Randomized run against the reference model
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b111111) w[31:26] = 6'b001001;
            rom[i] = w;
        end
        do_reset(2);
        model_pc = 32'd0;
        for (int n = 0; n < 60; n++) begin
            logic br, asel, lsel, tkn;
            logic [31:0] rs;
            br   = 1'($urandom_range(0, 1));
            asel = 1'($urandom_range(0, 3) == 0);
            lsel = 1'($urandom_range(0, 1));
            tkn  = 1'($urandom_range(0, 1));
            rs   = $urandom;
            is_branch = br; branch_addr_sel = asel; lbl_sel = lsel;
            branch_taken = tkn; rs_data = rs;
            instr_ready = 1'($urandom_range(0, 1));
            wait_valid("rnd", ok);
            if (!ok) break;
            instr_ready = 1'b0;
            w = rom[model_pc[9:0]];
            chk("rnd_pc", pc, model_pc);
            chk("rnd_instr", instr, w);
            k = $urandom_range(0, 2);
            for (int s = 0; s < k; s++) begin
                step();
                chk("rnd_hold", {31'd0, instr_valid}, 32'd1);
            end
            is_branch = br; branch_addr_sel = asel; lbl_sel = lsel;
            branch_taken = tkn; rs_data = rs;
            fire();
            model_pc = ref_next(model_pc, w, br, asel, lsel, tkn, rs);
            chk("rnd_next_pc", pc, model_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
